// File: rtl/keypad_decoder.sv
// 4x4 keypad scanner with debounce and key-class decode.
// Emits one pulse per accepted key; values hold until the next key of that class.
module keypad_decoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] num_val,
  output logic [1:0] op_val,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_num;
  logic [1:0]    r_op;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [1:0]    w_nxt_col;
  logic [1:0]    w_nxt_row;
  logic [3:0]    w_nxt_num;
  logic [1:0]    w_nxt_op;

  logic [3:0] w_rows_s;
  logic       w_any_low;
  logic       w_row_low;
  logic [1:0] w_low_row;
  logic       w_dig;
  logic       w_opk;
  logic       w_eqk;
  logic       w_clrk;
  logic [3:0] w_digit;

  assign w_rows_s  = r_sync2;
  assign w_any_low = ~&w_rows_s;
  assign w_row_low = ~w_rows_s[r_row];

  always_comb begin
    w_low_row = 2'd3;
    if (!w_rows_s[0])      w_low_row = 2'd0;
    else if (!w_rows_s[1]) w_low_row = 2'd1;
    else if (!w_rows_s[2]) w_low_row = 2'd2;
  end

  always_comb begin
    w_dig  = 1'b0;
    w_opk  = 1'b0;
    w_eqk  = 1'b0;
    w_clrk = 1'b0;
    unique case (1'b1)
      (r_col == 2'd3):                    w_opk  = 1'b1;
      (r_row == 2'd3 && r_col == 2'd0):   w_clrk = 1'b1;
      (r_row == 2'd3 && r_col == 2'd2):   w_eqk  = 1'b1;
      default:                            w_dig  = 1'b1;
    endcase
  end

  // Rows 0-2 hold 1..9 laid out three per row; row 3 only carries '0'.
  assign w_digit = (r_row == 2'd3) ? 4'd0 :
                   ({2'b00, r_row} * 4'd3) + {2'b00, r_col} + 4'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_col   = r_col;
    w_nxt_row   = r_row;
    w_nxt_num   = r_num;
    w_nxt_op    = r_op;
    unique case (r_state)
      SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_nxt_cnt = '0;
          if (w_any_low) begin
            w_nxt_row   = w_low_row;
            w_nxt_state = DEBOUNCE;
          end else begin
            w_nxt_col = r_col + 2'd1;
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (w_row_low) begin
          if (r_cnt == DEB_LAST) begin
            w_nxt_state = EMIT;
            w_nxt_cnt   = '0;
            if (w_dig) w_nxt_num = w_digit;
            if (w_opk) w_nxt_op  = r_row;
          end else begin
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end else begin
          w_nxt_state = SCAN;
          w_nxt_cnt   = '0;
          w_nxt_col   = r_col + 2'd1;
        end
      end
      EMIT: begin
        w_nxt_state = RELEASE;
        w_nxt_cnt   = '0;
      end
      RELEASE: begin
        if (&w_rows_s) begin
          if (r_cnt == DEB_LAST) begin
            w_nxt_state = SCAN;
            w_nxt_cnt   = '0;
            w_nxt_col   = r_col + 2'd1;
          end else begin
            w_nxt_cnt = r_cnt + CNT_ONE;
          end
        end else begin
          w_nxt_cnt = '0;
        end
      end
      default: w_nxt_state = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SCAN;
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_cnt   <= '0;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_num   <= 4'd0;
      r_op    <= 2'd0;
    end else begin
      r_state <= w_nxt_state;
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      r_cnt   <= w_nxt_cnt;
      r_col   <= w_nxt_col;
      r_row   <= w_nxt_row;
      r_num   <= w_nxt_num;
      r_op    <= w_nxt_op;
    end
  end

  assign col_out = ~(4'b0001 << r_col);
  assign num_val = r_num;
  assign op_val  = r_op;
  assign is_num  = (r_state == EMIT) && w_dig;
  assign is_op   = (r_state == EMIT) && w_opk;
  assign is_eq   = (r_state == EMIT) && w_eqk;
  assign is_clr  = (r_state == EMIT) && w_clrk;

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder with a behavioural keypad matrix.
// Expected pulses are queued by stimulus and checked by an output monitor.
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] num_val;
  logic [1:0] op_val;
  logic       is_num;
  logic       is_op;
  logic       is_eq;
  logic       is_clr;

  logic [3:0][3:0] pressed;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] num;
    logic [1:0] op;
  } exp_t;

  exp_t sb[$];
  logic [3:0] m_num = 4'd0;
  logic [1:0] m_op  = 2'd0;

  always #5 clk = ~clk;

  keypad_decoder #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .num_val(num_val),
    .op_val(op_val),
    .is_num(is_num),
    .is_op(is_op),
    .is_eq(is_eq),
    .is_clr(is_clr)
  );

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] p;
    exp_t e;
    if (mon_en) begin
      p = {is_clr, is_eq, is_op, is_num};
      if (p != 4'd0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {28'd0, p}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {28'd0, p}, {28'd0, e.p});
          check("num_val", {28'd0, num_val}, {28'd0, e.num});
          check("op_val", {30'd0, op_val}, {30'd0, e.op});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_num(input logic [3:0] d);
    m_num = d;
    sb.push_back({4'b0001, m_num, m_op});
  endtask

  task automatic exp_op(input logic [1:0] o);
    m_op = o;
    sb.push_back({4'b0010, m_num, m_op});
  endtask

  task automatic exp_eq();
    sb.push_back({4'b0100, m_num, m_op});
  endtask

  task automatic key(input int r, input int c);
    pressed[r][c] = 1'b1;
    tick(60);
    pressed = '0;
    tick(40);
  endtask

  // Returns #1 after the edge where col_out first switches to target.
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col_out;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (col_out == target && prev != target) begin
        found = 1'b1;
        break;
      end
      prev = col_out;
    end
    check("wait_col_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    pressed = '0;
    rst = 1'b0;
    tick(3);
    mon_en = 1'b1;
    check("rst_col", {28'd0, col_out}, 32'hE);
    check("rst_num", {28'd0, num_val}, 32'd0);
    check("rst_op", {30'd0, op_val}, 32'd0);
    check("rst_pulses", {28'd0, is_clr, is_eq, is_op, is_num}, 32'd0);
    rst = 1'b1;
    tick(3);
    check("col_hold_c0", {28'd0, col_out}, 32'hE);
    tick(1);
    check("col_adv_c1", {28'd0, col_out}, 32'hD);

    exp_num(4'd5);
    pressed[1][1] = 1'b1;
    tick(60);
    check("release_hold_c1", {28'd0, col_out}, 32'hD);
    pressed = '0;
    tick(9);
    check("release_wait_c1", {28'd0, col_out}, 32'hD);
    tick(1);
    check("resume_c2", {28'd0, col_out}, 32'hB);
    tick(30);

    exp_op(2'd2);
    key(2, 3);
    exp_eq();
    key(3, 2);

    wait_col(4'hB);
    pressed[2][2] = 1'b1;
    tick(3);
    pressed[2][2] = 1'b0;
    tick(1);
    pressed[2][2] = 1'b1;
    tick(2);
    check("bounce_abort_c3", {28'd0, col_out}, 32'h7);
    exp_num(4'd9);
    tick(60);
    pressed = '0;
    tick(40);

    wait_col(4'hB);
    pressed[0][2] = 1'b1;
    pressed[0][3] = 1'b1;
    exp_num(4'd3);
    tick(60);
    pressed = '0;
    tick(40);

    pressed[1][0] = 1'b1;
    pressed[2][0] = 1'b1;
    exp_num(4'd4);
    tick(60);
    pressed = '0;
    tick(40);

    wait_col(4'hE);
    pressed[3][0] = 1'b1;
    tick(9);
    rst = 1'b0;
    tick(1);
    check("midrst_col", {28'd0, col_out}, 32'hE);
    check("midrst_num", {28'd0, num_val}, 32'd0);
    check("midrst_op", {30'd0, op_val}, 32'd0);
    pressed = '0;
    m_num = 4'd0;
    m_op  = 2'd0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("postrst_col", {28'd0, col_out}, 32'hE);
    tick(30);

    exp_num(4'd8);
    key(2, 1);

    tick(5);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each column stays driven during scanning.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 50000: consecutive stable cycles needed to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port row_in, input, 4 bits: keypad rows, active-low, asynchronous, pulled up externally.
REQ-006 The block SHALL have port col_out, output, 4 bits: keypad column drive, active-low, one-hot-low.
REQ-007 The block SHALL have port num_val, output, 4 bits: digit 0-9 of the last accepted numeric key.
REQ-008 The block SHALL have port op_val, output, 2 bits: operator of the last accepted operator key (00 +, 01 -, 10 *, 11 /).
REQ-009 The block SHALL have port is_num, output, 1 bit: one-cycle pulse marking an accepted digit key.
REQ-010 The block SHALL have port is_op, output, 1 bit: one-cycle pulse marking an accepted operator key.
REQ-011 The block SHALL have port is_eq, output, 1 bit: one-cycle pulse marking an accepted '=' key.
REQ-012 The block SHALL have port is_clr, output, 1 bit: one-cycle pulse marking an accepted 'C' key.

Function
REQ-013 The block SHALL pass row_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value rows_s.
REQ-014 The key map SHALL be (row r, column c): r0 = 1 2 3 +; r1 = 4 5 6 -; r2 = 7 8 9 *; r3 = C 0 = /.
REQ-015 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, EMIT, RELEASE.
REQ-016 In SCAN, the block SHALL drive one column low for SCAN_DIV cycles, then advance c0->c1->c2->c3->c0 (wrap-around).
REQ-017 In SCAN, on the last cycle of a column slot, if any rows_s bit is 0, the block SHALL latch the column index and the lowest-index low row, then enter DEBOUNCE without advancing the column.
REQ-018 In DEBOUNCE, the block SHALL hold the column and count cycles in which the latched row stays low; any cycle in which it reads high SHALL return the FSM to SCAN at the next column with no pulse.
REQ-019 After DEBOUNCE_CNT consecutive low cycles, the FSM SHALL enter EMIT.
REQ-020 EMIT SHALL last exactly one cycle, and exactly one of is_num/is_op/is_eq/is_clr SHALL be 1 in that cycle.
REQ-021 In the EMIT cycle, num_val (digit keys) or op_val (operator keys) SHALL already carry the decoded value; the other value SHALL keep its previous contents.
REQ-022 num_val and op_val SHALL hold their values until the next EMIT of the same key class.
REQ-023 In RELEASE, the block SHALL hold the column and require rows_s == 4'b1111 for DEBOUNCE_CNT consecutive cycles before returning to SCAN at the next column; any low row SHALL restart the count.
REQ-024 Key presses occurring during RELEASE (same or other column) SHALL be ignored; no pulse SHALL be issued until release completes and a new SCAN detection occurs.
REQ-025 Multiple low rows in the scanned column SHALL resolve to the lowest row index.
REQ-026 Counters SHALL be sized ceil(log2(max(SCAN_DIV, DEBOUNCE_CNT)+1)) bits and SHALL never wrap during counting.
REQ-027 Outside EMIT, all four pulse outputs SHALL be 0.

Reset
REQ-028 While rst == 0 at a clock edge, the block SHALL set: state SCAN, col_out = 4'b1110, counters 0, num_val = 0, op_val = 0, all pulses 0, synchronizer flops = 1.
REQ-029 Reset asserted during DEBOUNCE, EMIT or RELEASE SHALL abort the operation with no pulse emitted on or after the reset edge.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 Reset check: hold rst=0 for 3 cycles -> col_out=1110, num_val=0, op_val=0, all pulses 0; after release, col_out becomes 1101 4 cycles later.
REQ-031 Digit key: hold key '5' (r1,c1) steady -> exactly one is_num pulse with num_val=5; no further pulse while held; after release and 8 high cycles, scanning resumes at c2.
REQ-032 Operator then equals: press '*' then '=' (each held, then released) -> is_op with op_val=10, then is_eq; num_val unchanged.
REQ-033 Bounce: '9' goes low 3 cycles, high 1 cycle, then low stable -> no pulse for the first burst; one is_num with num_val=9 after a full 8-cycle stable window.
REQ-034 Simultaneous keys: '3' and '+' both pressed (r0,c2 and r0,c3) -> single is_num with num_val=3; '+' ignored until all keys are released.
REQ-035 Reset mid-debounce: 'C' pressed, rst=0 at debounce count 5 -> is_clr never pulses; after reset, state is SCAN with col_out=1110.
